// File: rtl/control_unit_multicycle.sv
// Multicycle control FSM: IDLE/DECODE/EXEC/MEM/WB/FAULT with MEM timeout.
// Ports: clk, rst_n, instr_valid/instr_ready, tipo/op/Inm, mem_ready,
//   datapath strobes, ImmSrc, ALUControl, fault, state.
//   CU_RETIRE_CNT_EN adds the 16-bit retired output.
module control_unit_multicycle #(
  parameter int ALU_CTRL_W  = 3,
  parameter int IMM_SRC_W   = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            tipo,
  input  logic [1:0]            op,
  input  logic                  Inm,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  ResultSrc,
  output logic                  Branch,
  output logic [IMM_SRC_W-1:0]  ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  fault,
  output logic [2:0]            state
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [15:0]           retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       tipo_q, tipo_d;
  logic [1:0]       op_q, op_d;
  logic             inm_q, inm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_arith, is_ldr, is_str;
  logic is_b, is_cmp, illegal;
  logic [ALU_CTRL_W-1:0] dec_alu;
  logic [IMM_SRC_W-1:0]  dec_imm;
  logic                  dec_src;

  // Instruction class from the latched fields.
  always_comb begin
    is_arith = 1'b0;
    is_ldr   = 1'b0;
    is_str   = 1'b0;
    is_b     = 1'b0;
    is_cmp   = 1'b0;
    illegal  = 1'b0;
    unique case (1'b1)
      (tipo_q == 2'b00):
        is_arith = 1'b1;
      (tipo_q == 2'b01 && op_q == 2'b01):
        is_ldr = 1'b1;
      (tipo_q == 2'b01 && op_q == 2'b10):
        is_str = 1'b1;
      (tipo_q == 2'b10 && op_q == 2'b00):
        is_b = 1'b1;
      (tipo_q == 2'b10 && op_q == 2'b10):
        is_cmp = 1'b1;
      default:
        illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_alu = '0;
    dec_imm = '0;
    dec_src = 1'b0;
    unique case (1'b1)
      is_arith: begin
        dec_alu = ALU_CTRL_W'(op_q);
        dec_src = inm_q;
      end
      (is_ldr || is_str): begin
        dec_src = 1'b1;
        dec_imm = IMM_SRC_W'(1);
      end
      is_b: begin
        dec_imm = IMM_SRC_W'(2);
      end
      is_cmp: begin
        dec_alu = ALU_CTRL_W'(1);
        dec_src = inm_q;
      end
      default: begin
        dec_alu = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tipo_q  <= '0;
      op_q    <= '0;
      inm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tipo_q  <= tipo_d;
      op_q    <= op_d;
      inm_q   <= inm_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tipo_d      = tipo_q;
    op_d        = op_q;
    inm_d       = inm_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    ResultSrc   = 1'b0;
    Branch      = 1'b0;
    ImmSrc      = '0;
    ALUControl  = '0;
    fault       = 1'b0;

    // Decoded operand controls stay valid for the whole instruction.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ALUControl = dec_alu;
      ImmSrc     = dec_imm;
      ALUSrc     = dec_src;
    end

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          IRWrite = 1'b1;
          tipo_d  = tipo;
          op_d    = op;
          inm_d   = Inm;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = illegal ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        if (is_arith) begin
          state_d = S_WB;
        end else if (is_ldr || is_str) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else if (is_b) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
          state_d = S_IDLE;
        end else if (is_cmp) begin
          PCWrite = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_MEM: begin
        MemRead  = is_ldr;
        MemWrite = is_str;
        // mem_ready on the last allowed cycle beats the timeout.
        if (mem_ready) begin
          if (is_ldr) begin
            state_d = S_WB;
          end else begin
            PCWrite = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        ResultSrc = is_ldr;
        state_d   = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign state = state_q;

`ifdef CU_RETIRE_CNT_EN
  logic [15:0] ret_q, ret_d;

  always_comb begin
    ret_d = ret_q + 16'(PCWrite);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign retired = ret_q;
`endif

endmodule

// File: doc/control_unit_multicycle.md
CONTROL_UNIT_MULTICYCLE -- requirements
Module: control_unit_multicycle

Interface
REQ-001 Parameter ALU_CTRL_W, default 3: ALUControl width; must be at least 2.
REQ-002 Parameter IMM_SRC_W, default 2: ImmSrc width; must be at least 2.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum MEM wait cycles before fault; must be at least 1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 instr_valid  in  1  instruction fields valid.
REQ-007 instr_ready  out  1  block accepts an instruction (IDLE only).
REQ-008 tipo  in  2  instruction class.
REQ-009 op  in  2  operation within class.
REQ-010 Inm  in  1  immediate operand select.
REQ-011 mem_ready  in  1  memory access complete.
REQ-012 PCWrite, IRWrite, RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch  out  1 each  datapath strobes.
REQ-013 ImmSrc  out  IMM_SRC_W; ALUControl  out  ALU_CTRL_W.
REQ-014 fault  out  1  sticky illegal-instruction or timeout flag.
REQ-015 state  out  3  current FSM state encoding.

Function
REQ-016 State encodings SHALL be: IDLE=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
REQ-017 In IDLE, instr_ready SHALL be 1; instr_valid=1 SHALL latch tipo, op and Inm, pulse IRWrite for 1 cycle, and move to DECODE.
REQ-018 All outputs SHALL be Moore functions of state plus the latched fields; instr_valid outside IDLE SHALL be ignored.
REQ-019 Decode: tipo 00 op 00/01/10/11 = ADD/SUB/AND/OR, ALUControl 0/1/2/3, ALUSrc=Inm, ImmSrc=0.
REQ-020 Decode: tipo 01 op 01 = LDR, op 10 = STR, ALUSrc=1, ImmSrc=1, ALUControl=0.
REQ-021 Decode: tipo 10 op 00 = B (ImmSrc=2); tipo 10 op 10 = CMP (ALUControl=1, no RegWrite).
REQ-022 Illegal instructions SHALL be tipo 01 op 00/11, tipo 10 op 01/11, and any tipo 11.
REQ-023 DECODE SHALL go to FAULT on an illegal instruction and to EXEC otherwise.
REQ-024 EXEC transitions: arithmetic goes to WB; LDR/STR go to MEM; B asserts Branch=1 and PCWrite=1 and goes to IDLE; CMP asserts PCWrite=1 and goes to IDLE.
REQ-025 In MEM, MemRead (LDR) or MemWrite (STR) SHALL be held at 1 until mem_ready=1.
REQ-026 On mem_ready in MEM, LDR SHALL go to WB; STR SHALL pulse PCWrite and go to IDLE.
REQ-027 The MEM wait counter SHALL be ceil(log2(MEM_TIMEOUT+1)) bits and clear on MEM entry.
REQ-028 If MEM_TIMEOUT cycles elapse in MEM without mem_ready, the FSM SHALL go to FAULT; mem_ready on the final cycle SHALL win.
REQ-029 WB SHALL assert RegWrite=1 and PCWrite=1, set ResultSrc=1 for LDR and 0 otherwise, then go to IDLE.
REQ-030 FAULT SHALL be terminal until reset: fault=1, all strobes 0, instr_ready=0.
REQ-031 Latency from accept to PCWrite SHALL be 4 cycles for arithmetic, 3 for B/CMP, and 4+w (STR) or 5+w (LDR) for memory, where w is the number of MEM wait cycles.
REQ-032 mem_ready outside MEM SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, clear the latched fields, the counter and fault, and drive all strobes, ImmSrc and ALUControl to 0.
REQ-034 Reset mid-operation SHALL abandon the instruction with no further strobes.

Configuration
REQ-035 With CU_RETIRE_CNT_EN defined, the block SHALL provide a 16-bit output retired that increments on every PCWrite pulse and wraps from 0xFFFF to 0; reset SHALL clear it to 0.
REQ-036 Without CU_RETIRE_CNT_EN, the retired port and its counter SHALL be absent, with no other behavioural change.

Verification
REQ-037 ADD with Inm=1 -> IRWrite at cycle 1, ALUSrc=1 and ALUControl=0 in EXEC, RegWrite=1 and PCWrite=1 at cycle 4, then IDLE.
REQ-038 LDR with mem_ready after 3 wait cycles -> MemRead=1 for 4 cycles, then WB with ResultSrc=1; PCWrite at cycle 8.
REQ-039 STR with mem_ready held 0 and MEM_TIMEOUT=15 -> MemWrite=1 for 15 cycles, then fault=1 and state=5 until reset.
REQ-040 tipo=11 -> FAULT after DECODE, no RegWrite or MemWrite ever; rst_n pulse -> state=0, fault=0.
REQ-041 B and CMP back-to-back, plus rst_n asserted during MEM -> Branch only on B, PCWrite at cycle 3 each; reset returns to IDLE with no further strobes.
REQ-042 With CU_RETIRE_CNT_EN defined, retired preset to 0xFFFF and one ADD executed -> retired=0.
